// File: rtl/mmu_itlb_wrctrl_pkg.sv
// Shared types for the ITLB RAM write-port scheduler: RAM address/data,
// write requests, write-source and flush-walker state encodings.
package mmu_itlb_wrctrl_pkg;

    localparam int TID_W  = 6;
    localparam int IDX_W  = 3;
    localparam int DATA_W = 32;

    typedef struct packed {
        logic clk;
    } iu_clk_type;

    typedef struct packed {
        logic [TID_W-1:0] tid;
        logic [IDX_W-1:0] idx;
    } mmu_itlbram_addr_type;

    typedef logic [DATA_W-1:0] mmu_itlbram_data_type;

    typedef struct packed {
        mmu_itlbram_addr_type addr;
        mmu_itlbram_data_type data;
    } mmu_itlb_wreq_type;

    typedef enum logic [2:0] {
        WS_NONE   = 3'd0,
        WS_IU     = 3'd1,
        WS_SCRUB  = 3'd2,
        WS_REFILL = 3'd3,
        WS_FLUSH  = 3'd4
    } wsrc_e;

    typedef enum logic [1:0] {
        FL_IDLE = 2'd0,
        FL_WALK = 2'd1,
        FL_DONE = 2'd2
    } flush_state_e;

    localparam logic [IDX_W-1:0] IDX_MAX = {IDX_W{1'b1}};

endpackage

// File: rtl/mmu_itlb_wrctrl_refill_fifo.sv
// Small {addr,data} FIFO buffering memory-side refills; a push while full is
// accepted when the same cycle also pops.
module mmu_itlb_refill_fifo
    import mmu_itlb_wrctrl_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  mmu_itlb_wreq_type push_data,
    input  logic              pop,
    output mmu_itlb_wreq_type pop_data,
    output logic              full,
    output logic              empty
);

    localparam int AW = $clog2(DEPTH);

    mmu_itlb_wreq_type mem_r [DEPTH];
    logic [AW:0] wr_ptr_r;
    logic [AW:0] rd_ptr_r;
    logic        do_pop_s;
    logic        do_push_s;

    assign empty     = (wr_ptr_r == rd_ptr_r);
    assign full      = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                       (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign do_pop_s  = pop && !empty;
    assign do_push_s = push && (!full || do_pop_s);
    assign pop_data  = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointers; the extra MSB separates full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
        end
    end

    // Entry storage; contents past the pointers are don't-care.
    always_ff @(posedge clk) begin
        if (do_push_s) mem_r[wr_ptr_r[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/mmu_itlb_wrctrl.sv
// ITLB RAM write-port scheduler: arbitrates IU, ECC scrub, buffered refill and
// per-thread flush writes onto one registered write port; reports ECC events.
module mmu_itlb_wrctrl
    import mmu_itlb_wrctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 2,
    parameter int SBERR_CNT_W = 16
) (
    input  iu_clk_type              gclk,
    input  logic                    rst,
    input  logic                    iu_we,
    input  mmu_itlbram_addr_type    iu_addr,
    input  mmu_itlbram_data_type    iu_data,
    input  logic                    mem_valid,
    output logic                    mem_ready,
    input  mmu_itlbram_addr_type    mem_addr,
    input  mmu_itlbram_data_type    mem_data,
    input  logic                    flush_req,
    input  logic [TID_W-1:0]        flush_tid,
    output logic                    flush_busy,
    output logic                    flush_done,
    input  mmu_itlbram_addr_type    rd_addr,
    input  mmu_itlbram_data_type    ram_rdata,
    input  logic                    ram_sberr,
    input  logic                    ram_dberr,
    output logic                    ram_we,
    output mmu_itlbram_addr_type    ram_waddr,
    output mmu_itlbram_data_type    ram_wdata,
    output logic [SBERR_CNT_W-1:0]  sberr_cnt,
    output logic                    dberr_pulse
);

    logic                 clk;
    logic                 fifo_full_s;
    logic                 fifo_empty_s;
    logic                 fifo_push_s;
    logic                 fifo_pop_s;
    mmu_itlb_wreq_type    fifo_head_s;
    mmu_itlb_wreq_type    mem_req_s;
    logic                 refill_discard_s;
    wsrc_e                wsel_s;
    mmu_itlb_wreq_type    wreq_s;
    flush_state_e         fl_state_r;
    flush_state_e         fl_next_s;
    logic [TID_W-1:0]     fl_tid_r;
    logic [IDX_W-1:0]     fl_idx_r;
    logic                 fl_walk_s;
    logic                 fl_done_s;
    mmu_itlbram_addr_type rd_addr_d_r;
    logic                 scrub_pend_r;
    mmu_itlb_wreq_type    scrub_req_r;
    logic                 scrub_walk_hit_s;
    logic                 scrub_cancel_s;
    logic                 sberr_ev_s;

    assign clk = gclk.clk;

    assign mem_req_s.addr = mem_addr;
    assign mem_req_s.data = mem_data;
    assign mem_ready      = !fifo_full_s;
    assign fifo_push_s    = mem_valid && !fifo_full_s;

    mmu_itlb_refill_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_refill_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push_s),
        .push_data (mem_req_s),
        .pop       (fifo_pop_s),
        .pop_data  (fifo_head_s),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

    // A refill for the thread being flushed is dropped instead of written back.
    assign refill_discard_s = fl_walk_s && !fifo_empty_s && (fifo_head_s.addr.tid == fl_tid_r);
    assign scrub_walk_hit_s = fl_walk_s && (scrub_req_r.addr.tid == fl_tid_r);
    assign fifo_pop_s       = (wsel_s == WS_REFILL) || refill_discard_s;
    assign sberr_ev_s       = ram_sberr && !ram_dberr;

    // Fixed-priority grant: IU > scrub > refill > flush.
    always_comb begin
        wsel_s = WS_NONE;
        if (iu_we) begin
            wsel_s = WS_IU;
        end else if (scrub_pend_r && !scrub_walk_hit_s) begin
            wsel_s = WS_SCRUB;
        end else if (!fifo_empty_s && !refill_discard_s) begin
            wsel_s = WS_REFILL;
        end else if (fl_walk_s) begin
            wsel_s = WS_FLUSH;
        end else begin
            wsel_s = WS_NONE;
        end
    end

    // Mux the granted request.
    always_comb begin
        wreq_s = '0;
        case (wsel_s)
            WS_IU: begin
                wreq_s.addr = iu_addr;
                wreq_s.data = iu_data;
            end
            WS_SCRUB:  wreq_s = scrub_req_r;
            WS_REFILL: wreq_s = fifo_head_s;
            WS_FLUSH: begin
                wreq_s.addr.tid = fl_tid_r;
                wreq_s.addr.idx = fl_idx_r;
                wreq_s.data     = '0;
            end
            default:   wreq_s = '0;
        endcase
    end

    // Registered RAM write port.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_we    <= 1'b0;
            ram_waddr <= '0;
            ram_wdata <= '0;
        end else begin
            ram_we    <= (wsel_s != WS_NONE);
            ram_waddr <= wreq_s.addr;
            ram_wdata <= wreq_s.data;
        end
    end

    // Flush walker state, latched thread and index.
    always_ff @(posedge clk) begin
        if (rst) begin
            fl_state_r <= FL_IDLE;
            fl_tid_r   <= '0;
            fl_idx_r   <= '0;
        end else begin
            fl_state_r <= fl_next_s;
            if ((fl_state_r == FL_IDLE) && flush_req) begin
                fl_tid_r <= flush_tid;
                fl_idx_r <= '0;
            end else if (wsel_s == WS_FLUSH) begin
                fl_idx_r <= fl_idx_r + {{(IDX_W-1){1'b0}}, 1'b1};
            end
        end
    end

    // Flush walker next state; the index only advances on a granted write.
    always_comb begin
        fl_next_s = fl_state_r;
        case (fl_state_r)
            FL_IDLE: fl_next_s = flush_req ? FL_WALK : FL_IDLE;
            FL_WALK: fl_next_s = ((wsel_s == WS_FLUSH) && (fl_idx_r == IDX_MAX)) ? FL_DONE : FL_WALK;
            FL_DONE: fl_next_s = FL_IDLE;
            default: fl_next_s = FL_IDLE;
        endcase
    end

    // Flush walker decoded outputs.
    always_comb begin
        fl_walk_s  = (fl_state_r == FL_WALK);
        fl_done_s  = (fl_state_r == FL_DONE);
        flush_busy = fl_walk_s;
    end

    // Cancel a pending scrub that a newer write or the flush would make stale.
    assign scrub_cancel_s = scrub_pend_r &&
        ((((wsel_s == WS_IU) || (wsel_s == WS_REFILL)) && (wreq_s.addr == scrub_req_r.addr)) ||
         scrub_walk_hit_s);

    // Scrubber: align read address with RAM data, hold one corrected entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_addr_d_r  <= '0;
            scrub_pend_r <= 1'b0;
            scrub_req_r  <= '0;
        end else begin
            rd_addr_d_r <= rd_addr;
            if (scrub_pend_r) begin
                if ((wsel_s == WS_SCRUB) || scrub_cancel_s) scrub_pend_r <= 1'b0;
            end else if (sberr_ev_s) begin
                scrub_pend_r     <= 1'b1;
                scrub_req_r.addr <= rd_addr_d_r;
                scrub_req_r.data <= ram_rdata;
            end
        end
    end

    // Status outputs: ECC event reporting and flush completion pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            sberr_cnt   <= '0;
            dberr_pulse <= 1'b0;
            flush_done  <= 1'b0;
        end else begin
            if (sberr_ev_s && (sberr_cnt != {SBERR_CNT_W{1'b1}})) begin
                sberr_cnt <= sberr_cnt + {{(SBERR_CNT_W-1){1'b0}}, 1'b1};
            end
            dberr_pulse <= ram_dberr;
            flush_done  <= fl_done_s;
        end
    end

endmodule

// File: tb/tb_mmu_itlb_wrctrl.sv
// Directed self-checking bench for mmu_itlb_wrctrl: reset, arbitration,
// flush walk, scrub, refill backpressure, flush/refill discard and ECC events.
module tb_mmu_itlb_wrctrl;
    import mmu_itlb_wrctrl_pkg::*;

    iu_clk_type           gclk;
    logic                 rst, iu_we, mem_valid, mem_ready, flush_req, flush_busy, flush_done;
    logic                 ram_sberr, ram_dberr, ram_we, dberr_pulse;
    mmu_itlbram_addr_type iu_addr, mem_addr, rd_addr, ram_waddr;
    mmu_itlbram_data_type iu_data, mem_data, ram_rdata, ram_wdata;
    logic [TID_W-1:0]     flush_tid;
    logic [15:0]          sberr_cnt;
    logic [15:0]          exp_sberr;
    int                   checks;
    int                   errors;

    mmu_itlb_wrctrl #(.FIFO_DEPTH(2), .SBERR_CNT_W(16)) dut (
        .gclk(gclk), .rst(rst), .iu_we(iu_we), .iu_addr(iu_addr), .iu_data(iu_data),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_data(mem_data),
        .flush_req(flush_req), .flush_tid(flush_tid), .flush_busy(flush_busy), .flush_done(flush_done),
        .rd_addr(rd_addr), .ram_rdata(ram_rdata), .ram_sberr(ram_sberr), .ram_dberr(ram_dberr),
        .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
        .sberr_cnt(sberr_cnt), .dberr_pulse(dberr_pulse)
    );

    initial gclk = '0;
    always #5 gclk.clk = ~gclk.clk;

    function automatic mmu_itlbram_addr_type mk(input int t, input int i);
        mmu_itlbram_addr_type a;
        a.tid = TID_W'(t);
        a.idx = IDX_W'(i);
        return a;
    endfunction

    task automatic tick();
        @(posedge gclk.clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) tick();
        checks++;
        if ({ram_we, ram_waddr, ram_wdata, flush_busy, flush_done, dberr_pulse, sberr_cnt} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got we=%b waddr=%h wdata=%h busy=%b done=%b dbp=%b cnt=%0d, expected all 0",
                     ram_we, ram_waddr, ram_wdata, flush_busy, flush_done, dberr_pulse, sberr_cnt);
        end
        checks++;
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL reset_mem_ready: got %b expected 1", mem_ready); end
        rst = 1'b0;
        iu_we = 1'b1; iu_addr = mk(1, 1); iu_data = 32'h0000_5A5A;
        tick();
        iu_we = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(1, 1) || ram_wdata !== 32'h0000_5A5A) begin
            errors++;
            $display("FAIL first_iu_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=00005a5a",
                     ram_we, ram_waddr, ram_wdata, mk(1, 1));
        end
    endtask

    task automatic test_iu_refill();
        iu_we = 1'b1; iu_addr = mk(1, 2); iu_data = 32'h11;
        mem_valid = 1'b1; mem_addr = mk(3, 4); mem_data = 32'h22;
        tick();
        iu_we = 1'b0; mem_valid = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(1, 2) || ram_wdata !== 32'h11) begin
            errors++;
            $display("FAIL iu_over_refill_t1: got we=%b addr=%h data=%h expected we=1 addr=%h data=11",
                     ram_we, ram_waddr, ram_wdata, mk(1, 2));
        end
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(3, 4) || ram_wdata !== 32'h22) begin
            errors++;
            $display("FAIL iu_over_refill_t2: got we=%b addr=%h data=%h expected we=1 addr=%h data=22",
                     ram_we, ram_waddr, ram_wdata, mk(3, 4));
        end
        tick();
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL iu_over_refill_idle: got we=%b expected 0", ram_we); end
    endtask

    task automatic test_flush(input bit inject);
        logic                 e_we, e_done;
        mmu_itlbram_addr_type e_addr;
        mmu_itlbram_data_type e_data;
        flush_req = 1'b1; flush_tid = 6'd5;
        tick();
        flush_req = 1'b0;
        checks++;
        if (flush_busy !== 1'b1) begin errors++; $display("FAIL flush_busy_set: got %b expected 1", flush_busy); end
        for (int c = 2; c <= 11; c++) begin
            iu_we = inject && (c == 5); iu_addr = mk(9, 0); iu_data = 32'hAB;
            tick();
            iu_we = 1'b0;
            e_we = 1'b1; e_done = 1'b0; e_data = '0; e_addr = '0;
            if (!inject) begin
                if (c <= 9) e_addr = mk(5, c - 2);
                else begin e_we = 1'b0; e_done = (c == 10); end
            end else begin
                if (c <= 4) e_addr = mk(5, c - 2);
                else if (c == 5) begin e_addr = mk(9, 0); e_data = 32'hAB; end
                else if (c <= 10) e_addr = mk(5, c - 3);
                else begin e_we = 1'b0; e_done = 1'b1; end
            end
            checks++;
            if (ram_we !== e_we || flush_done !== e_done || (e_we && (ram_waddr !== e_addr || ram_wdata !== e_data))) begin
                errors++;
                $display("FAIL flush_walk(inject=%0d) t+%0d: got we=%b addr=%h data=%h done=%b expected we=%b addr=%h data=%h done=%b",
                         inject, c, ram_we, ram_waddr, ram_wdata, flush_done, e_we, e_addr, e_data, e_done);
            end
        end
        tick();
        checks++;
        if (flush_busy !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL flush_end: got busy=%b done=%b expected 0 0", flush_busy, flush_done);
        end
    endtask

    task automatic test_scrub();
        rd_addr = mk(2, 3);
        tick();
        rd_addr = mk(0, 0); ram_sberr = 1'b1; ram_rdata = 32'hD00D_0001;
        tick();
        ram_sberr = 1'b0;
        exp_sberr = exp_sberr + 16'd1;
        checks++;
        if (sberr_cnt !== exp_sberr) begin errors++; $display("FAIL scrub_count: got %0d expected %0d", sberr_cnt, exp_sberr); end
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(2, 3) || ram_wdata !== 32'hD00D_0001) begin
            errors++;
            $display("FAIL scrub_write: got we=%b addr=%h data=%h expected we=1 addr=%h data=d00d0001",
                     ram_we, ram_waddr, ram_wdata, mk(2, 3));
        end
        // Second scrub, cancelled by an IU write to the same address.
        rd_addr = mk(2, 3);
        tick();
        rd_addr = mk(0, 0); ram_sberr = 1'b1; ram_rdata = 32'hD00D_0002;
        tick();
        ram_sberr = 1'b0;
        exp_sberr = exp_sberr + 16'd1;
        iu_we = 1'b1; iu_addr = mk(2, 3); iu_data = 32'hE0E0_0003;
        tick();
        iu_we = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_wdata !== 32'hE0E0_0003) begin
            errors++;
            $display("FAIL scrub_iu_write: got we=%b data=%h expected we=1 data=e0e00003", ram_we, ram_wdata);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (ram_we !== 1'b0) begin
                errors++;
                $display("FAIL scrub_cancel: got we=%b addr=%h data=%h expected no write", ram_we, ram_waddr, ram_wdata);
            end
        end
        checks++;
        if (sberr_cnt !== exp_sberr) begin errors++; $display("FAIL scrub_count2: got %0d expected %0d", sberr_cnt, exp_sberr); end
    endtask

    task automatic test_backpressure();
        iu_we = 1'b1; iu_addr = mk(10, 0); iu_data = 32'h1;
        mem_valid = 1'b1; mem_addr = mk(3, 0); mem_data = 32'hA0;
        checks++;
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_ready0: got %b expected 1", mem_ready); end
        tick();
        iu_addr = mk(10, 1); mem_addr = mk(3, 1); mem_data = 32'hA1;
        checks++;
        if (mem_ready !== 1'b1) begin errors++; $display("FAIL bp_ready1: got %b expected 1", mem_ready); end
        tick();
        iu_addr = mk(10, 2); mem_addr = mk(3, 2); mem_data = 32'hA2;
        checks++;
        if (mem_ready !== 1'b0) begin errors++; $display("FAIL bp_full: got %b expected 0", mem_ready); end
        tick();
        checks++;
        if (mem_ready !== 1'b0 || ram_we !== 1'b1 || ram_waddr !== mk(10, 2)) begin
            errors++;
            $display("FAIL bp_iu_wins: got ready=%b we=%b addr=%h expected ready=0 we=1 addr=%h",
                     mem_ready, ram_we, ram_waddr, mk(10, 2));
        end
        iu_we = 1'b0;
        tick();
        checks++;
        if (ram_waddr !== mk(3, 0) || ram_wdata !== 32'hA0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill0: got addr=%h data=%h ready=%b expected addr=%h data=a0 ready=1",
                     ram_waddr, ram_wdata, mem_ready, mk(3, 0));
        end
        tick();
        mem_valid = 1'b0;
        checks++;
        if (ram_waddr !== mk(3, 1) || ram_wdata !== 32'hA1) begin
            errors++;
            $display("FAIL bp_refill1: got addr=%h data=%h expected addr=%h data=a1", ram_waddr, ram_wdata, mk(3, 1));
        end
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(3, 2) || ram_wdata !== 32'hA2 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_refill2: got we=%b addr=%h data=%h ready=%b expected we=1 addr=%h data=a2 ready=1",
                     ram_we, ram_waddr, ram_wdata, mem_ready, mk(3, 2));
        end
        tick();
        checks++;
        if (ram_we !== 1'b0) begin errors++; $display("FAIL bp_drained: got we=%b expected 0", ram_we); end
    endtask

    task automatic test_flush_discard();
        bit seen_done;
        iu_we = 1'b1; iu_addr = mk(7, 0); iu_data = 32'h70;
        mem_valid = 1'b1; mem_addr = mk(4, 1); mem_data = 32'h41;
        flush_req = 1'b1; flush_tid = 6'd4;
        tick();
        iu_we = 1'b0; flush_req = 1'b0;
        mem_addr = mk(6, 1); mem_data = 32'h61;
        tick();
        mem_valid = 1'b0;
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(4, 0) || ram_wdata !== 32'h0) begin
            errors++;
            $display("FAIL discard_first_flush: got we=%b addr=%h data=%h expected we=1 addr=%h data=0",
                     ram_we, ram_waddr, ram_wdata, mk(4, 0));
        end
        tick();
        checks++;
        if (ram_we !== 1'b1 || ram_waddr !== mk(6, 1) || ram_wdata !== 32'h61) begin
            errors++;
            $display("FAIL discard_other_refill: got we=%b addr=%h data=%h expected we=1 addr=%h data=61",
                     ram_we, ram_waddr, ram_wdata, mk(6, 1));
        end
        seen_done = 1'b0;
        for (int k = 0; k < 20 && !seen_done; k++) begin
            tick();
            seen_done = flush_done;
            checks++;
            if (ram_we && (ram_wdata !== 32'h0 || ram_waddr.tid !== 6'd4)) begin
                errors++;
                $display("FAIL discard_leak: got addr=%h data=%h expected only zero flush writes to tid 4", ram_waddr, ram_wdata);
            end
        end
        checks++;
        if (!seen_done) begin errors++; $display("FAIL discard_done_timeout: got no flush_done expected pulse within 20 cycles"); end
        tick();
    endtask

    task automatic test_dberr();
        ram_dberr = 1'b1; ram_sberr = 1'b1; ram_rdata = 32'hDEAD;
        tick();
        ram_dberr = 1'b0; ram_sberr = 1'b0;
        checks++;
        if (dberr_pulse !== 1'b1 || sberr_cnt !== exp_sberr || ram_we !== 1'b0) begin
            errors++;
            $display("FAIL dberr_event: got pulse=%b cnt=%0d we=%b expected pulse=1 cnt=%0d we=0",
                     dberr_pulse, sberr_cnt, ram_we, exp_sberr);
        end
        for (int k = 0; k < 2; k++) begin
            tick();
            checks++;
            if (dberr_pulse !== 1'b0 || ram_we !== 1'b0) begin
                errors++;
                $display("FAIL dberr_no_scrub: got pulse=%b we=%b expected 0 0", dberr_pulse, ram_we);
            end
        end
    endtask

    task automatic test_reset_abort();
        flush_req = 1'b1; flush_tid = 6'd3;
        tick();
        flush_req = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (flush_busy !== 1'b0 || ram_we !== 1'b0 || sberr_cnt !== 16'd0 || mem_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_abort: got busy=%b we=%b cnt=%0d ready=%b expected 0 0 0 1",
                     flush_busy, ram_we, sberr_cnt, mem_ready);
        end
        tick();
        checks++;
        if (ram_we !== 1'b0 || flush_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_abort_quiet: got we=%b done=%b expected 0 0", ram_we, flush_done);
        end
    endtask

    initial begin
        checks = 0; errors = 0; exp_sberr = 16'd0;
        rst = 1'b1; iu_we = 1'b0; mem_valid = 1'b0; flush_req = 1'b0; flush_tid = '0;
        ram_sberr = 1'b0; ram_dberr = 1'b0;
        iu_addr = '0; mem_addr = '0; rd_addr = '0;
        iu_data = '0; mem_data = '0; ram_rdata = '0;
        test_reset();
        test_iu_refill();
        test_flush(1'b0);
        test_flush(1'b1);
        test_scrub();
        test_backpressure();
        test_flush_discard();
        test_dberr();
        test_reset_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
